// File: rtl/rv_instr_loader.sv
// Boot-time program loader: encodes field-level RV32I instructions and writes
// them sequentially into instruction memory, one word every two cycles.
module rv_instr_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [3:0]        in_funct,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_unsup,
  output logic              err_ovf
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IALU   = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
  localparam logic [31:0]       NOP_WORD   = 32'h0000_0013;

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr;
  logic              last_r;
  logic              unsup_r;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] enc_word;
  logic        enc_unsup;

  assign opcode = {in_op, 2'b11};
  assign f3     = in_funct[2:0];
  assign f7     = {1'b0, in_funct[3], 5'b00000};

  // Illegal funct3 values and unknown op classes collapse to a NOP plus a flag.
  always_comb begin
    enc_word  = NOP_WORD;
    enc_unsup = 1'b0;
    case (in_op)
      OP_R: enc_word = {f7, in_rs2, in_rs1, f3, in_rd, opcode};
      OP_IALU: begin
        if (f3 == 3'b001 || f3 == 3'b101)
          enc_word = {f7, in_imm[4:0], in_rs1, f3, in_rd, opcode};
        else
          enc_word = {in_imm[11:0], in_rs1, f3, in_rd, opcode};
      end
      OP_LOAD: begin
        if (f3 == 3'b011 || f3[2:1] == 2'b11)
          enc_unsup = 1'b1;
        else
          enc_word = {in_imm[11:0], in_rs1, f3, in_rd, opcode};
      end
      OP_JALR: enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, opcode};
      OP_STORE: begin
        if (f3[2] || f3 == 3'b011)
          enc_unsup = 1'b1;
        else
          enc_word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opcode};
      end
      OP_BRANCH: begin
        if (f3[2:1] == 2'b01)
          enc_unsup = 1'b1;
        else
          enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                      in_imm[4:1], in_imm[11], opcode};
      end
      OP_LUI, OP_AUIPC: enc_word = {in_imm[31:12], in_rd, opcode};
      OP_JAL: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                          in_rd, opcode};
      default: enc_unsup = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: if (start) next_state = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) next_state = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
        if (last_r || addr == LAST_ADDR) next_state = DONE;
        else                             next_state = LOAD;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // mem_addr is latched at the handshake so it stays put while addr advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= START_ADDR;
      mem_addr  <= '0;
      mem_wdata <= '0;
      last_r    <= 1'b0;
      unsup_r   <= 1'b0;
      err_unsup <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= START_ADDR;
            err_unsup <= 1'b0;
            err_ovf   <= 1'b0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            mem_wdata <= enc_word;
            mem_addr  <= addr;
            last_r    <= in_last;
            unsup_r   <= enc_unsup;
          end
        end
        WRITE: begin
          if (unsup_r) err_unsup <= 1'b1;
          if (!last_r) begin
            if (addr == LAST_ADDR) err_ovf <= 1'b1;
            else                   addr    <= addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_instr_loader.sv
// Directed bench for rv_instr_loader: a spec-level encoder model fills an
// expected-write queue that a per-cycle compare process drains.
module tb_rv_instr_loader;

  localparam int ADDR_W = 2;
  localparam int BASE   = 0;
  localparam int CAP    = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op;
  logic [3:0]        in_funct;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err_unsup;
  logic              err_ovf;

  rv_instr_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_funct(in_funct), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err_unsup(err_unsup), .err_ovf(err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       word;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   sess_idx = 0;
  bit   m_unsup  = 0;
  bit   m_ovf    = 0;
  bit   prev_we  = 0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Instruction words laid out straight from the RV32I format tables.
  function automatic logic [31:0] model_encode(
      input logic [4:0] op, input logic [3:0] funct, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
      output bit unsup);
    logic [31:0] w;
    logic [6:0]  opc;
    logic [2:0]  fn3;
    logic [6:0]  fn7;
    opc   = {op, 2'b11};
    fn3   = funct[2:0];
    fn7   = funct[3] ? 7'b0100000 : 7'b0000000;
    unsup = 0;
    w     = 32'h0;
    if (op == 5'b01100) w = {fn7, rs2, rs1, fn3, rd, opc};
    else if (op == 5'b00100 && (fn3 == 3'd1 || fn3 == 3'd5))
      w = {fn7, imm[4:0], rs1, fn3, rd, opc};
    else if (op == 5'b00100) w = {imm[11:0], rs1, fn3, rd, opc};
    else if (op == 5'b00000) begin
      if (fn3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) w = {imm[11:0], rs1, fn3, rd, opc};
      else unsup = 1;
    end
    else if (op == 5'b11001) w = {imm[11:0], rs1, 3'd0, rd, opc};
    else if (op == 5'b01000) begin
      if (fn3 inside {3'd0, 3'd1, 3'd2}) w = {imm[11:5], rs2, rs1, fn3, imm[4:0], opc};
      else unsup = 1;
    end
    else if (op == 5'b11000) begin
      if (fn3 inside {3'd2, 3'd3}) unsup = 1;
      else w = {imm[12], imm[10:5], rs2, rs1, fn3, imm[4:1], imm[11], opc};
    end
    else if (op == 5'b01101 || op == 5'b00101) w = {imm[31:12], rd, opc};
    else if (op == 5'b11011) w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
    else unsup = 1;
    if (unsup) w = 32'h0000_0013;
    return w;
  endfunction

  always @(negedge clk) begin
    if (rst) prev_we = 0;
    else begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL unexpected_write: got write addr=%0d data=%h, expected no write",
                   mem_addr, mem_wdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("write_addr", 32'(mem_addr), 32'(e.addr));
          checkOutput("write_data", mem_wdata, e.word);
          checkOutput("ready_low_in_write", 32'(in_ready), 32'd0);
          checkOutput("busy_in_write", 32'(busy), 32'd1);
        end
      end
      if (done) begin
        checkOutput("done_follows_write", 32'(prev_we), 32'd1);
        checkOutput("done_not_busy", 32'(busy), 32'd0);
      end
      if (in_ready) checkOutput("ready_implies_busy", 32'(busy), 32'd1);
      prev_we = mem_we;
    end
  end

  task automatic startSession();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    exp_q.delete();
    sess_idx = 0;
    m_unsup  = 0;
    m_ovf    = 0;
    checkOutput("start_ready", 32'(in_ready), 32'd1);
    checkOutput("start_busy", 32'(busy), 32'd1);
    checkOutput("start_clears_unsup", 32'(err_unsup), 32'd0);
    checkOutput("start_clears_ovf", 32'(err_ovf), 32'd0);
  endtask

  task automatic applyStimulus(input logic [4:0] op, input logic [3:0] funct,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm,
                               input logic last);
    bit   accepted;
    bit   u;
    exp_t e;
    accepted = 0;
    in_op = op; in_funct = funct; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_last = last; in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (in_ready) begin
        e.addr = ADDR_W'(BASE + sess_idx);
        e.word = model_encode(op, funct, rd, rs1, rs2, imm, u);
        exp_q.push_back(e);
        if (u) m_unsup = 1;
        sess_idx++;
        if (!last && sess_idx == CAP) m_ovf = 1;
        @(posedge clk);
        #1;
        accepted = 1;
        break;
      end
    end
    in_valid = 1'b0;
    checkOutput("handshake", 32'(accepted), 32'd1);
  endtask

  task automatic endSession(output int cycles);
    bit seen;
    seen   = 0;
    cycles = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done) begin
        seen   = 1;
        cycles = c;
        break;
      end
    end
    checkOutput("done_seen", 32'(seen), 32'd1);
    checkOutput("err_unsup", 32'(err_unsup), 32'(m_unsup));
    checkOutput("err_ovf", 32'(err_ovf), 32'(m_ovf));
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  cyc;
    int  ready_seen;
    bit  u;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_op = '0; in_funct = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_last = 1'b0;

    #3;
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_errs", 32'({err_unsup, err_ovf}), 32'd0);
    checkOutput("rst_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);

    // Hand-computed encodings that pin the model.
    checkOutput("model_addi", model_encode(5'b00100, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd5, u), 32'h00500093);
    checkOutput("model_sub", model_encode(5'b01100, 4'b1000, 5'd3, 5'd1, 5'd2, 32'd0, u), 32'h402081B3);
    checkOutput("model_srai", model_encode(5'b00100, 4'b1101, 5'd5, 5'd6, 5'd0, 32'd3, u), 32'h40335293);
    checkOutput("model_beq", model_encode(5'b11000, 4'b0000, 5'd0, 5'd1, 5'd2, 32'd8, u), 32'h00208463);
    checkOutput("model_jal", model_encode(5'b11011, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd16, u), 32'h010000EF);
    checkOutput("model_sw", model_encode(5'b01000, 4'b0010, 5'd0, 5'd2, 5'd5, 32'd12, u), 32'h00512623);
    checkOutput("model_lui", model_encode(5'b01101, 4'b0000, 5'd7, 5'd0, 5'd0, 32'h12345000, u), 32'h123453B7);
    checkOutput("model_unsup", model_encode(5'b11111, 4'b0000, 5'd1, 5'd2, 5'd3, 32'd4, u), 32'h00000013);
    checkOutput("model_unsup_flag", 32'(u), 32'd1);

    #9 rst = 1'b0;

    $display("[TB] single addi");
    startSession();
    applyStimulus(5'b00100, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    @(negedge clk);
    checkOutput("t1_we", 32'(mem_we), 32'd1);
    checkOutput("t1_addr", 32'(mem_addr), 32'd0);
    checkOutput("t1_wdata", mem_wdata, 32'h00500093);
    endSession(cyc);
    checkOutput("t1_done_latency", 32'(cyc), 32'd1);
    checkOutput("t1_addr_hold", 32'(mem_addr), 32'd0);
    checkOutput("t1_wdata_hold", mem_wdata, 32'h00500093);

    $display("[TB] sub + srai stream");
    startSession();
    applyStimulus(5'b01100, 4'b1000, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    applyStimulus(5'b00100, 4'b1101, 5'd5, 5'd6, 5'd0, 32'd3, 1'b1);
    endSession(cyc);

    $display("[TB] beq + jal");
    startSession();
    applyStimulus(5'b11000, 4'b0000, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    applyStimulus(5'b11011, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd16, 1'b1);
    endSession(cyc);

    $display("[TB] unsupported op");
    startSession();
    applyStimulus(5'b11111, 4'b0000, 5'd1, 5'd2, 5'd3, 32'd4, 1'b1);
    endSession(cyc);
    checkOutput("t4_unsup_sticky", 32'(err_unsup), 32'd1);

    $display("[TB] mixed formats, last on final address");
    startSession();
    applyStimulus(5'b01000, 4'b0010, 5'd0, 5'd2, 5'd5, 32'd12, 1'b0);
    applyStimulus(5'b00000, 4'b0010, 5'd4, 5'd3, 5'd0, 32'hFFFF_FFFC, 1'b0);
    applyStimulus(5'b01101, 4'b0000, 5'd7, 5'd0, 5'd0, 32'h1234_5000, 1'b0);
    applyStimulus(5'b11000, 4'b0011, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1);
    endSession(cyc);

    $display("[TB] overflow without last");
    startSession();
    applyStimulus(5'b00101, 4'b0000, 5'd9, 5'd0, 5'd0, 32'hABCD_E000, 1'b0);
    applyStimulus(5'b11001, 4'b0111, 5'd1, 5'd4, 5'd0, 32'd20, 1'b0);
    applyStimulus(5'b00100, 4'b0101, 5'd2, 5'd3, 5'd0, 32'd31, 1'b0);
    applyStimulus(5'b00000, 4'b0110, 5'd2, 5'd3, 5'd0, 32'd0, 1'b0);
    in_op = 5'b00100; in_funct = 4'b0000; in_rd = 5'd8; in_rs1 = 5'd0;
    in_imm = 32'd1; in_last = 1'b1; in_valid = 1'b1;
    endSession(cyc);
    ready_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (in_ready) ready_seen++;
    end
    in_valid = 1'b0;
    checkOutput("t6_fifth_not_accepted", 32'(ready_seen), 32'd0);

    $display("[TB] reset during write");
    startSession();
    applyStimulus(5'b00100, 4'b0000, 5'd2, 5'd0, 5'd0, 32'd7, 1'b0);
    #1 rst = 1'b1;
    #1;
    checkOutput("t7_we_drop", 32'(mem_we), 32'd0);
    checkOutput("t7_busy_drop", 32'(busy), 32'd0);
    checkOutput("t7_ready_drop", 32'(in_ready), 32'd0);
    exp_q.delete();
    #20 rst = 1'b0;
    startSession();
    applyStimulus(5'b00100, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    @(negedge clk);
    checkOutput("t7_restart_we", 32'(mem_we), 32'd1);
    checkOutput("t7_restart_addr", 32'(mem_addr), 32'(BASE));
    endSession(cyc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
